// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch PC with prioritised redirect and registered fetch queue
// Optional feature macro: IFETCH_STALL_CNT_EN (enables the 16-bit saturating fetch-stall counter).
module ifetch_queue #(
   parameter int          AW       = 10,
   parameter int          IW       = 10,
   parameter int          QDEPTH   = 4,
   parameter int          NSRC     = 3,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pc_en,
   input  logic [NSRC-1:0]              redir_valid,
   input  logic [NSRC*AW-1:0]           redir_target,
   output logic [AW-1:0]                imem_addr,
   input  logic [IW-1:0]                imem_data,
   input  logic                         imem_ready,
   output logic [IW-1:0]                instr_out,
   output logic [AW-1:0]                pc_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(QDEPTH+1)-1:0]  fill_level,
   output logic [15:0]                  stall_cnt
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH+1);
   localparam logic [CW-1:0] FULL_LVL = CW'(QDEPTH);

   logic [AW-1:0]    pc_q;
   logic [AW+IW-1:0] mem_q [QDEPTH];
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    count_q;

   logic             any_redir;
   logic [AW-1:0]    redir_pc;
   logic             full;
   logic             pop;
   logic             push;

   // Pick the redirect target; scanning downwards lets the lowest active index win.
   always_comb begin
      any_redir = |redir_valid;
      redir_pc  = '0;
      for (int k = NSRC-1; k >= 0; k--) begin
         if (redir_valid[k]) begin
            redir_pc = redir_target[k*AW +: AW];
         end
      end
   end

   assign full      = (count_q == FULL_LVL);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = pc_en && imem_ready && (!full || pop) && !any_redir;

   assign imem_addr  = pc_q;
   assign fill_level = count_q;
   assign {pc_out, instr_out} = mem_q[head_q];

   // PC register: reset beats redirect, redirect beats sequential advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= AW'(RESET_PC);
      end else if (any_redir) begin
         pc_q <= redir_pc;
      end else if (push) begin
         pc_q <= pc_q + AW'(1);
      end
   end

   // Queue pointers and occupancy; a redirect flushes everything, including a same-cycle pop.
   always_ff @(posedge clk) begin
      if (reset || any_redir) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= tail_q + PW'(1);
         end
         if (pop) begin
            head_q <= head_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents beyond the live window are never observed, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[tail_q] <= {pc_q, imem_data};
      end
   end

`ifdef IFETCH_STALL_CNT_EN
   logic [15:0] stall_q;

   // Count cycles where fetch is enabled but nothing is available downstream.
   always_ff @(posedge clk) begin
      if (reset || any_redir) begin
         stall_q <= '0;
      end else if (pc_en && !out_valid && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized scoreboard bench for ifetch_queue
module tb_ifetch_queue;

   localparam int          AW       = 10;
   localparam int          IW       = 10;
   localparam int          QDEPTH   = 4;
   localparam int          NSRC     = 3;
   localparam int unsigned RESET_PC = 0;
   localparam int          CW       = $clog2(QDEPTH+1);
`ifdef IFETCH_STALL_CNT_EN
   localparam int          STALL_EXP = 3;
`else
   localparam int          STALL_EXP = 0;
`endif

   logic                 clk;
   logic                 reset;
   logic                 pc_en;
   logic [NSRC-1:0]      redir_valid;
   logic [NSRC*AW-1:0]   redir_target;
   logic [AW-1:0]        imem_addr;
   logic [IW-1:0]        imem_data;
   logic                 imem_ready;
   logic [IW-1:0]        instr_out;
   logic [AW-1:0]        pc_out;
   logic                 out_valid;
   logic                 out_ready;
   logic [CW-1:0]        fill_level;
   logic [15:0]          stall_cnt;

   ifetch_queue #(
      .AW(AW), .IW(IW), .QDEPTH(QDEPTH), .NSRC(NSRC), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .reset(reset), .pc_en(pc_en),
      .redir_valid(redir_valid), .redir_target(redir_target),
      .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
      .instr_out(instr_out), .pc_out(pc_out), .out_valid(out_valid),
      .out_ready(out_ready), .fill_level(fill_level), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW+IW-1:0] exp_q[$];
   logic [AW-1:0]    m_pc       = '0;
   logic [15:0]      m_stall    = '0;
   bit               mon_en     = 1'b0;
   bit               pend_flush = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict the edge from the reference rules, apply after the edge.
   task automatic step(input bit rst, input bit pe, input bit ir, input bit ordy,
                       input logic [NSRC-1:0] rv, input logic [NSRC*AW-1:0] rt,
                       input logic [IW-1:0] d);
      bit            redir;
      bit            popm;
      bit            pushm;
      logic [AW-1:0] tgt;
      logic [AW-1:0] npc;
      logic [15:0]   nst;
      int            sz;
      reset        = rst;
      pc_en        = pe;
      imem_ready   = ir;
      out_ready    = ordy;
      redir_valid  = rv;
      redir_target = rt;
      imem_data    = d;
      sz    = exp_q.size();
      redir = (rv != '0);
      tgt   = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (rv[k]) begin
            tgt = rt[k*AW +: AW];
            break;
         end
      end
      popm  = (sz > 0) && ordy;
      pushm = !rst && !redir && pe && ir && ((sz < QDEPTH) || popm);
      pend_flush = rst || redir;
      if (rst)        npc = AW'(RESET_PC);
      else if (redir) npc = tgt;
      else if (pushm) npc = m_pc + AW'(1);
      else            npc = m_pc;
`ifdef IFETCH_STALL_CNT_EN
      if (rst || redir)                                    nst = 16'd0;
      else if (pe && (sz == 0) && (m_stall != 16'hFFFF))   nst = m_stall + 16'd1;
      else                                                 nst = m_stall;
`else
      nst = 16'd0;
`endif
      @(posedge clk);
      if (pend_flush)  exp_q.delete();
      else if (pushm)  exp_q.push_back({m_pc, d});
      m_pc       = npc;
      m_stall    = nst;
      pend_flush = 1'b0;
      #1;
   endtask

   // Monitor: compares DUT state each cycle and retires the head whenever the DUT hands it off.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("imem_addr", 32'(imem_addr), 32'(m_pc));
            check("fill_level", 32'(fill_level), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            if (out_valid && (exp_q.size() > 0)) begin
               check("head", 32'({pc_out, instr_out}), 32'(exp_q[0]));
               if (out_ready && !pend_flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [63:0] r;
      bit          rst, pe, ir, ordy;
      logic [NSRC-1:0] rv;
      reset = 1'b1; pc_en = 1'b0; imem_ready = 1'b0; out_ready = 1'b0;
      redir_valid = '0; redir_target = '0; imem_data = '0;

      step(1, 0, 0, 0, '0, '0, '0);
      step(1, 0, 0, 0, '0, '0, '0);
      mon_en = 1'b1;
      check("rst_addr", 32'(imem_addr), RESET_PC);
      check("rst_fill", 32'(fill_level), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_stall", 32'(stall_cnt), 0);

      // Fill with consumer stalled: PC advances 0..4 then holds at full.
      for (int i = 0; i < 5; i++) begin
         check("fill_addr", 32'(imem_addr), 32'(i));
         step(0, 1, 1, 0, '0, '0, IW'($urandom));
      end
      check("fill_addr_hold", 32'(imem_addr), 4);
      check("fill_full", 32'(fill_level), QDEPTH);
      check("fill_head_pc", 32'(pc_out), 0);

      // Full queue with simultaneous push and pop.
      for (int i = 0; i < 3; i++) begin
         check("pushpop_pc", 32'(pc_out), 32'(i));
         step(0, 1, 1, 1, '0, '0, IW'($urandom));
      end
      check("pushpop_fill", 32'(fill_level), QDEPTH);

      // Two sources active: index 1 wins over index 2.
      step(0, 1, 1, 1, 3'b110, {10'h100, 10'h050, 10'h000}, IW'($urandom));
      check("redir_addr", 32'(imem_addr), 32'h050);
      check("redir_fill", 32'(fill_level), 0);
      check("redir_valid", 32'(out_valid), 0);

      // PC wraps from all-ones to zero.
      step(0, 0, 0, 0, 3'b001, {10'h000, 10'h000, 10'h3FF}, '0);
      check("wrap_pre", 32'(imem_addr), 32'h3FF);
      step(0, 1, 1, 0, '0, '0, 10'h2AB);
      check("wrap_addr", 32'(imem_addr), 0);
      check("wrap_head", 32'({pc_out, instr_out}), 32'({10'h3FF, 10'h2AB}));

      // Memory not ready with an empty queue.
      step(1, 0, 0, 0, '0, '0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0, '0, IW'($urandom));
      check("stall_addr", 32'(imem_addr), RESET_PC);
      check("stall_cnt3", 32'(stall_cnt), STALL_EXP);

      // Reset wins over a simultaneous redirect with entries queued.
      step(0, 1, 1, 0, '0, '0, IW'($urandom));
      step(0, 1, 1, 0, '0, '0, IW'($urandom));
      check("pre_rst_fill", 32'(fill_level), 2);
      step(1, 1, 1, 1, 3'b001, {10'h000, 10'h000, 10'h123}, IW'($urandom));
      check("rst_redir_addr", 32'(imem_addr), RESET_PC);
      check("rst_redir_fill", 32'(fill_level), 0);

      // Randomized traffic; consumer eagerness alternates by phase to visit full and empty.
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 99) == 0);
         rv   = ($urandom_range(0, 11) == 0) ? NSRC'($urandom) : '0;
         r    = {$urandom, $urandom};
         pe   = ($urandom_range(0, 7) != 0);
         ir   = ($urandom_range(0, 3) != 0);
         ordy = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step(rst, pe, ir, ordy, rv, r[NSRC*AW-1:0], IW'($urandom));
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter AW, default 10: PC/address width in bits.
REQ-002 SHALL have parameter IW, default 10: instruction width in bits.
REQ-003 SHALL have parameter QDEPTH, default 4: fetch-queue entries; power of two, at least 2.
REQ-004 SHALL have parameter NSRC, default 3: number of redirect sources; at least 1.
REQ-005 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port pc_en, input, 1: fetch enable; 0 holds PC and blocks queue pushes.
REQ-009 SHALL have port redir_valid, input, NSRC: per-source redirect request; bit 0 has highest priority.
REQ-010 SHALL have port redir_target, input, NSRC*AW: per-source target; source k occupies bits [k*AW +: AW].
REQ-011 SHALL have port imem_addr, output, AW: current PC driven to instruction memory or cache.
REQ-012 SHALL have port imem_data, input, IW: instruction at imem_addr, valid in the same cycle.
REQ-013 SHALL have port imem_ready, input, 1: imem_data is valid this cycle.
REQ-014 SHALL have port instr_out, output, IW: instruction at the queue head.
REQ-015 SHALL have port pc_out, output, AW: PC of the queue-head instruction.
REQ-016 SHALL have port out_valid, output, 1: queue non-empty.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts the head this cycle.
REQ-018 SHALL have port fill_level, output, $clog2(QDEPTH+1): current number of entries.
REQ-019 SHALL have port stall_cnt, output, 16: fetch-stall counter (see Configuration).

Function
REQ-020 SHALL define push as pc_en && imem_ready && (not full || pop) && no redirect_valid bit set.
REQ-021 SHALL define pop as out_valid && out_ready.
REQ-022 SHALL, on push, write {PC, imem_data} at the tail and set PC <= PC+1, modulo 2^AW (wraps from all-ones to 0).
REQ-023 SHALL hold PC and the queue contents when pc_en=0 or imem_ready=0, unless a redirect is active.
REQ-024 SHALL, when any redir_valid bit is 1, select the lowest-index active source, set PC <= its target, flush all entries (fill_level=0 next cycle), and suppress push; this overrides pc_en and pop.
REQ-025 SHALL allow simultaneous push and pop in every state, including full, leaving fill_level unchanged.
REQ-026 SHALL drive imem_addr directly from the PC register (zero combinational path from redirect inputs).
REQ-027 SHALL drive instr_out and pc_out from the head entry; their values are don't-care when out_valid=0.
REQ-028 SHALL keep head data stable while out_valid=1 and out_ready=0.
REQ-029 SHALL have a push-to-out_valid latency of one cycle (registered queue, no bypass).
REQ-030 SHALL never underflow (pop with empty queue has no effect) or overflow (no push when full without pop).

Reset
REQ-031 SHALL, with reset=1 at a clock edge, set PC=RESET_PC, fill_level=0, out_valid=0, stall_cnt=0; reset has priority over redirect, push and pop.
REQ-032 SHALL, when reset is asserted mid-operation, discard all queued entries with no partial state retained.

Configuration
REQ-033 SHALL, with macro IFETCH_STALL_CNT_EN defined, increment stall_cnt each cycle with pc_en=1 && out_valid=0 && not reset, saturating at 16'hFFFF, cleared by reset or any redirect.
REQ-034 SHALL, without IFETCH_STALL_CNT_EN, tie stall_cnt to 0 and synthesise no counter logic.

Verification
REQ-035 SHALL cover: reset, then pc_en=1, imem_ready=1, out_ready=0 for 5 cycles -> imem_addr 0,1,2,3,4,4; fill_level reaches 4 and holds; pc_out at the head = 0.
REQ-036 SHALL cover: full queue, out_ready=1 for 3 cycles -> 3 pops and 3 pushes; fill_level stays 4; pc_out sequence 0,1,2.
REQ-037 SHALL cover: redir_valid=3'b110 with targets 0x100 and 0x050 -> next imem_addr=0x050, fill_level=0, out_valid=0.
REQ-038 SHALL cover: PC=0x3FF (AW=10) with a push -> next imem_addr=0x000.
REQ-039 SHALL cover: imem_ready=0 for 3 cycles with IFETCH_STALL_CNT_EN defined and an empty queue -> PC unchanged, stall_cnt=3.
REQ-040 SHALL cover: reset asserted with 2 entries queued and a simultaneous redirect -> imem_addr=RESET_PC, fill_level=0.
